// File: rtl/calc_seq.sv
// calc_seq: start/busy/done sequencing controller for the calculator datapath.
// One 4-bit adder slice is used for every operation. ADD and SUB take two
// nibble cycles. MUL is unsigned shift-and-add over 8 iterations, and each
// iteration takes three cycles (low nibble, high nibble, shift). SHL and
// reserved opcodes finish in the capture cycle. Results are registered and
// hold until the next completion.
module calc_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [2:0] Op,
    output logic [7:0] Y,
    output logic       C,
    output logic       Of,
    output logic       err,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXLO  = 3'd1,
        S_EXHI  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;

    // The shared adder slice: 4-bit sum plus carry out in bit 4.
    function automatic logic [4:0] add4(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic       cin);
        add4 = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    endfunction

    state_t      state_r;
    state_t      next_state_s;

    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [2:0]  op_r;
    logic [16:0] p_r;        // MUL product/multiplier register, bit 16 = add carry
    logic [2:0]  cnt_r;      // MUL iteration counter
    logic [3:0]  lo_r;       // ADD/SUB low result nibble
    logic        cy_r;       // nibble carry between EXLO and EXHI

    logic [7:0]  y_r;
    logic        c_r;
    logic        of_r;
    logic        err_r;
    logic        busy_r;
    logic        done_r;

    logic        is_mul_s;
    logic        is_sub_s;
    logic [3:0]  mul_mask_s;
    logic [3:0]  add_a_s;
    logic [3:0]  add_b_s;
    logic        add_cin_s;
    logic [4:0]  add_s;
    logic [16:0] p_shift_s;

    logic        ld_res_s;
    logic [7:0]  y_nxt_s;
    logic        c_nxt_s;
    logic        of_nxt_s;
    logic        err_nxt_s;

    assign is_mul_s   = (op_r == OP_MUL);
    assign is_sub_s   = (op_r == OP_SUB);
    assign mul_mask_s = {4{p_r[0]}};
    assign add_s      = add4(add_a_s, add_b_s, add_cin_s);
    assign p_shift_s  = {1'b0, p_r[16], p_r[15:1]};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    case (Op)
                        OP_ADD:  next_state_s = S_EXLO;
                        OP_SUB:  next_state_s = S_EXLO;
                        OP_MUL:  next_state_s = S_EXLO;
                        default: next_state_s = S_DONE;   // SHL and reserved
                    endcase
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_EXLO:  next_state_s = S_EXHI;
            S_EXHI: begin
                if (is_mul_s) begin
                    next_state_s = S_SHIFT;
                end else begin
                    next_state_s = S_DONE;
                end
            end
            S_SHIFT: begin
                if (cnt_r == 3'd7) begin
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_EXLO;
                end
            end
            S_DONE:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // Adder operand steering: ADD/SUB use A and B (or ~B), MUL adds A or zero to P high byte.
    always_comb begin
        add_a_s   = 4'h0;
        add_b_s   = 4'h0;
        add_cin_s = 1'b0;
        case (state_r)
            S_EXLO: begin
                if (is_mul_s) begin
                    add_a_s = p_r[11:8];
                    add_b_s = a_r[3:0] & mul_mask_s;
                end else begin
                    add_a_s = a_r[3:0];
                    add_b_s = is_sub_s ? ~b_r[3:0] : b_r[3:0];
                end
                add_cin_s = is_sub_s;
            end
            S_EXHI: begin
                if (is_mul_s) begin
                    add_a_s = p_r[15:12];
                    add_b_s = a_r[7:4] & mul_mask_s;
                end else begin
                    add_a_s = a_r[7:4];
                    add_b_s = is_sub_s ? ~b_r[7:4] : b_r[7:4];
                end
                add_cin_s = cy_r;
            end
            default: begin
                add_a_s   = 4'h0;
                add_b_s   = 4'h0;
                add_cin_s = 1'b0;
            end
        endcase
    end

    // Result load decode: what gets written into Y/C/Of/err on the edge entering DONE.
    always_comb begin
        ld_res_s  = 1'b0;
        y_nxt_s   = 8'h00;
        c_nxt_s   = 1'b0;
        of_nxt_s  = 1'b0;
        err_nxt_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start && (Op == OP_SHL)) begin
                    ld_res_s = 1'b1;
                    y_nxt_s  = {A[6:0], 1'b0};
                    c_nxt_s  = A[7];
                    of_nxt_s = A[7] ^ A[6];
                end else if (start && Op[2]) begin
                    ld_res_s  = 1'b1;
                    err_nxt_s = 1'b1;
                end else begin
                    ld_res_s = 1'b0;
                end
            end
            S_EXHI: begin
                if (!is_mul_s) begin
                    ld_res_s = 1'b1;
                    y_nxt_s  = {add_s[3:0], lo_r};
                    c_nxt_s  = add_s[4];
                    if (is_sub_s) begin
                        of_nxt_s = (a_r[7] != b_r[7]) && (add_s[3] != a_r[7]);
                    end else begin
                        of_nxt_s = (a_r[7] == b_r[7]) && (add_s[3] != a_r[7]);
                    end
                end else begin
                    ld_res_s = 1'b0;
                end
            end
            S_SHIFT: begin
                if (cnt_r == 3'd7) begin
                    ld_res_s = 1'b1;
                    y_nxt_s  = p_shift_s[7:0];
                    c_nxt_s  = |p_shift_s[15:8];
                end else begin
                    ld_res_s = 1'b0;
                end
            end
            default: begin
                ld_res_s = 1'b0;
            end
        endcase
    end

    // Operand capture and working registers for the nibble sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r   <= 8'h00;
            b_r   <= 8'h00;
            op_r  <= 3'b000;
            p_r   <= 17'h00000;
            cnt_r <= 3'd0;
            lo_r  <= 4'h0;
            cy_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        a_r   <= A;
                        b_r   <= B;
                        op_r  <= Op;
                        p_r   <= {9'h000, B};
                        cnt_r <= 3'd0;
                        lo_r  <= 4'h0;
                        cy_r  <= 1'b0;
                    end
                end
                S_EXLO: begin
                    if (is_mul_s) begin
                        p_r[11:8] <= add_s[3:0];
                    end else begin
                        lo_r <= add_s[3:0];
                    end
                    cy_r <= add_s[4];
                end
                S_EXHI: begin
                    if (is_mul_s) begin
                        p_r[16:12] <= add_s;
                    end
                end
                S_SHIFT: begin
                    p_r   <= p_shift_s;
                    cnt_r <= cnt_r + 3'd1;
                end
                default: begin
                    cy_r <= cy_r;
                end
            endcase
        end
    end

    // Result registers: written only on the edge entering DONE, held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_r   <= 8'h00;
            c_r   <= 1'b0;
            of_r  <= 1'b0;
            err_r <= 1'b0;
        end else if (ld_res_s) begin
            y_r   <= y_nxt_s;
            c_r   <= c_nxt_s;
            of_r  <= of_nxt_s;
            err_r <= err_nxt_s;
        end
    end

    // Handshake flags registered from the next state so they track state_r exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s != S_IDLE);
            done_r <= (next_state_s == S_DONE);
        end
    end

    assign Y    = y_r;
    assign C    = c_r;
    assign Of   = of_r;
    assign err  = err_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_calc_seq.sv
// Directed testbench for calc_seq with hand-computed expected values.
module tb_calc_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] Op;
    logic [7:0] Y;
    logic       C;
    logic       Of;
    logic       err;
    logic       busy;
    logic       done;

    int tests;
    int fails;
    int lat;
    int n;

    calc_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Op    (Op),
        .Y     (Y),
        .C     (C),
        .Of    (Of),
        .err   (err),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and count the edges after the capture edge until done is high.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int latency);
        A = a;
        B = b;
        Op = op;
        start = 1'b1;
        tick();
        start = 1'b0;
        A = ~a;
        B = ~b;
        Op = 3'b110;
        latency = 0;
        while (!done && latency < 100) begin
            tick();
            latency++;
        end
    endtask

    // Step past the DONE cycle and confirm the pulse was a single cycle.
    task automatic finish_op(input string tag);
        tick();
        chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        start = 1'b0;
        A = 8'h00;
        B = 8'h00;
        Op = 3'b000;
        #12;
        chk("rst_Y",    {24'd0, Y},    32'h00);
        chk("rst_C",    {31'd0, C},    32'd0);
        chk("rst_Of",   {31'd0, Of},   32'd0);
        chk("rst_err",  {31'd0, err},  32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b1;
        tick();
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // ADD 0x7F + 0x01
        run_op(3'b000, 8'h7F, 8'h01, lat);
        chk("add1_lat", lat, 32'd2);
        chk("add1_Y",   {24'd0, Y},   32'h80);
        chk("add1_C",   {31'd0, C},   32'd0);
        chk("add1_Of",  {31'd0, Of},  32'd1);
        chk("add1_err", {31'd0, err}, 32'd0);
        chk("add1_busy", {31'd0, busy}, 32'd1);
        finish_op("add1");

        // ADD 0xFF + 0x01
        run_op(3'b000, 8'hFF, 8'h01, lat);
        chk("add2_lat", lat, 32'd2);
        chk("add2_Y",   {24'd0, Y},   32'h00);
        chk("add2_C",   {31'd0, C},   32'd1);
        chk("add2_Of",  {31'd0, Of},  32'd0);
        finish_op("add2");

        // SUB 0x05 - 0x07
        run_op(3'b001, 8'h05, 8'h07, lat);
        chk("sub1_lat", lat, 32'd2);
        chk("sub1_Y",   {24'd0, Y},   32'hFE);
        chk("sub1_C",   {31'd0, C},   32'd0);
        chk("sub1_Of",  {31'd0, Of},  32'd0);
        finish_op("sub1");

        // SUB 0x80 - 0x01
        run_op(3'b001, 8'h80, 8'h01, lat);
        chk("sub2_lat", lat, 32'd2);
        chk("sub2_Y",   {24'd0, Y},   32'h7F);
        chk("sub2_C",   {31'd0, C},   32'd1);
        chk("sub2_Of",  {31'd0, Of},  32'd1);
        finish_op("sub2");

        // Result hold across idle cycles
        tick();
        tick();
        tick();
        chk("hold_Y",  {24'd0, Y},  32'h7F);
        chk("hold_Of", {31'd0, Of}, 32'd1);

        // SHL 0xC0
        run_op(3'b010, 8'hC0, 8'h00, lat);
        chk("shl_lat", lat, 32'd0);
        chk("shl_Y",   {24'd0, Y},   32'h80);
        chk("shl_C",   {31'd0, C},   32'd1);
        chk("shl_Of",  {31'd0, Of},  32'd0);
        chk("shl_err", {31'd0, err}, 32'd0);
        finish_op("shl");

        // Reserved opcode 101
        run_op(3'b101, 8'h12, 8'h34, lat);
        chk("rsv_lat", lat, 32'd0);
        chk("rsv_Y",   {24'd0, Y},   32'h00);
        chk("rsv_C",   {31'd0, C},   32'd0);
        chk("rsv_err", {31'd0, err}, 32'd1);
        finish_op("rsv");

        // MUL 0x0F * 0x11 = 0x00FF
        run_op(3'b011, 8'h0F, 8'h11, lat);
        chk("mul1_lat", lat, 32'd24);
        chk("mul1_Y",   {24'd0, Y},   32'hFF);
        chk("mul1_C",   {31'd0, C},   32'd0);
        chk("mul1_Of",  {31'd0, Of},  32'd0);
        chk("mul1_err", {31'd0, err}, 32'd0);
        finish_op("mul1");

        // MUL 0x10 * 0x10 = 0x0100
        run_op(3'b011, 8'h10, 8'h10, lat);
        chk("mul2_lat", lat, 32'd24);
        chk("mul2_Y",   {24'd0, Y},   32'h00);
        chk("mul2_C",   {31'd0, C},   32'd1);
        finish_op("mul2");

        // MUL 0x0F * 0x11 with start pulses at cycles 3 and 10 and input churn
        A = 8'h0F;
        B = 8'h11;
        Op = 3'b011;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            n++;
            start = (n == 3) || (n == 10);
            A = (n == 3) ? 8'h55 : ((n == 10) ? 8'hC0 : 8'h80 + 8'(n));
            B = (n == 3) ? 8'h33 : 8'h7E;
            Op = (n == 3) ? 3'b000 : 3'b010;
            tick();
            if (n == 5) begin
                chk("ign_busy_mid", {31'd0, busy}, 32'd1);
            end
        end
        start = 1'b0;
        chk("ign_lat", n, 32'd24);
        chk("ign_Y",   {24'd0, Y}, 32'hFF);
        chk("ign_C",   {31'd0, C}, 32'd0);
        finish_op("ign");

        // Reset at cycle 12 of a MUL
        A = 8'h10;
        B = 8'h10;
        Op = 3'b011;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) n++;
            tick();
        end
        chk("rmul_no_early_done", n, 32'd0);
        rst = 1'b0;
        #1;
        chk("rmul_Y",    {24'd0, Y},    32'h00);
        chk("rmul_C",    {31'd0, C},    32'd0);
        chk("rmul_Of",   {31'd0, Of},   32'd0);
        chk("rmul_busy", {31'd0, busy}, 32'd0);
        chk("rmul_done", {31'd0, done}, 32'd0);
        tick();
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done || busy) n++;
        end
        chk("rmul_quiet", n, 32'd0);

        // ADD 0x02 + 0x03 after reset
        run_op(3'b000, 8'h02, 8'h03, lat);
        chk("radd_lat", lat, 32'd2);
        chk("radd_Y",   {24'd0, Y}, 32'h05);
        chk("radd_C",   {31'd0, C}, 32'd0);
        finish_op("radd");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
